// File: rtl/alu_arbiter_if.sv
// alu_arbiter bus bundle: two client request/response
// ports, the shared ALU connection and the busy flag.
interface alu_arbiter_if #(
   parameter int alu_op_size      = 4,
   parameter int alu_operand_size = 32
);
   logic                        req0_valid;
   logic                        req0_ready;
   logic [alu_op_size-1:0]      req0_alu_op;
   logic [alu_operand_size-1:0] req0_op1;
   logic [alu_operand_size-1:0] req0_op2;
   logic [2:0]                  req0_branch;
   logic                        req1_valid;
   logic                        req1_ready;
   logic [alu_op_size-1:0]      req1_alu_op;
   logic [alu_operand_size-1:0] req1_op1;
   logic [alu_operand_size-1:0] req1_op2;
   logic [2:0]                  req1_branch;
   logic                        rsp0_valid;
   logic                        rsp0_ready;
   logic                        rsp1_valid;
   logic                        rsp1_ready;
   logic [alu_operand_size-1:0] rsp_result;
   logic                        rsp_zero;
   logic [alu_op_size-1:0]      alu_alu_op;
   logic [alu_operand_size-1:0] alu_op1;
   logic [alu_operand_size-1:0] alu_op2;
   logic [2:0]                  alu_branch;
   logic [alu_operand_size-1:0] alu_result;
   logic                        alu_zero;
   logic                        busy;

   modport slave (
      input  req0_valid, req0_alu_op, req0_op1,
             req0_op2, req0_branch,
      input  req1_valid, req1_alu_op, req1_op1,
             req1_op2, req1_branch,
      input  rsp0_ready, rsp1_ready,
      input  alu_result, alu_zero,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid,
      output rsp_result, rsp_zero,
      output alu_alu_op, alu_op1, alu_op2, alu_branch,
      output busy
   );

   modport master (
      output req0_valid, req0_alu_op, req0_op1,
             req0_op2, req0_branch,
      output req1_valid, req1_alu_op, req1_op1,
             req1_op2, req1_branch,
      output rsp0_ready, rsp1_ready,
      output alu_result, alu_zero,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid,
      input  rsp_result, rsp_zero,
      input  alu_alu_op, alu_op1, alu_op2, alu_branch,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin two-client arbiter and sequencer
// for the shared combinational integer ALU.
module alu_arbiter #(
   parameter int alu_op_size      = 4,
   parameter int alu_operand_size = 32
) (
   input logic         clk,
   input logic         rst_n,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [alu_op_size-1:0]      alu_op;
      logic [alu_operand_size-1:0] op1;
      logic [alu_operand_size-1:0] op2;
      logic [2:0]                  branch;
   } fld_t;

   state_t state, state_nx;
   fld_t   lat, sel_f;
   logic   prio, gnt, sel, hs, done;

   // pick winner: sole requester, else the priority pointer
   always_comb begin
      sel = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid)
         sel = prio;
      sel_f = sel ?
         {bus.req1_alu_op, bus.req1_op1,
          bus.req1_op2, bus.req1_branch} :
         {bus.req0_alu_op, bus.req0_op1,
          bus.req0_op2, bus.req0_branch};
      hs   = bus.req0_ready | bus.req1_ready;
      done = (state == RESP) &&
             (gnt ? bus.rsp1_ready : bus.rsp0_ready);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (hs) state_nx = EXEC;
         EXEC:    state_nx = RESP;
         RESP:    if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // handshake outputs; ready held low while in reset
   always_comb begin
      bus.req0_ready = rst_n && (state == IDLE) &&
                       bus.req0_valid && !sel;
      bus.req1_ready = rst_n && (state == IDLE) &&
                       bus.req1_valid && sel;
      bus.rsp0_valid = (state == RESP) && !gnt;
      bus.rsp1_valid = (state == RESP) && gnt;
      bus.busy       = (state != IDLE);
   end

   // latch request fields, capture ALU result, rotate priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat            <= '0;
         gnt            <= 1'b0;
         prio           <= 1'b0;
         bus.rsp_result <= '0;
         bus.rsp_zero   <= 1'b0;
      end else begin
         if (hs) begin
            lat <= sel_f;
            gnt <= sel;
         end
         if (state == EXEC) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
         end
         if (done)
            prio <= ~gnt;
      end
   end

   // ALU always sees the latched fields
   always_comb begin
      bus.alu_alu_op = lat.alu_op;
      bus.alu_op1    = lat.op1;
      bus.alu_op2    = lat.op2;
      bus.alu_branch = lat.branch;
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small
// behavioural ALU attached to the alu_* port.
module tb_alu_arbiter;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [2:0] BEQ    = 3'd0;
   localparam logic [2:0] BNE    = 3'd1;
   localparam logic [2:0] BNONE  = 3'd2;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   alu_arbiter_if #(.alu_op_size(4), .alu_operand_size(32)) bus ();

   alu_arbiter #(.alu_op_size(4), .alu_operand_size(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // reference ALU
   always_comb begin
      unique case (bus.alu_alu_op)
         OP_ADD:  bus.alu_result = bus.alu_op1 + bus.alu_op2;
         OP_SUB:  bus.alu_result = bus.alu_op1 - bus.alu_op2;
         OP_AND:  bus.alu_result = bus.alu_op1 & bus.alu_op2;
         OP_OR:   bus.alu_result = bus.alu_op1 | bus.alu_op2;
         OP_XOR:  bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
         default: bus.alu_result = '0;
      endcase
      bus.alu_zero = 1'b0;
      if (bus.alu_branch == BEQ)
         bus.alu_zero = (bus.alu_result == 0);
      else if (bus.alu_branch == BNE)
         bus.alu_zero = (bus.alu_result != 0);
   end

   typedef struct {
      logic        v0;
      logic [3:0]  op0;
      logic [31:0] a0, b0;
      logic [2:0]  br0;
      logic        v1;
      logic [3:0]  op1;
      logic [31:0] a1, b1;
      logic [2:0]  br1;
      logic        gnt;
      logic [31:0] res;
      logic        chkz;
      logic        z;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(vec_t v);
      logic [31:0] wa;
      logic [3:0]  wop;
      bus.req0_valid  = v.v0;
      bus.req0_alu_op = v.op0;
      bus.req0_op1    = v.a0;
      bus.req0_op2    = v.b0;
      bus.req0_branch = v.br0;
      bus.req1_valid  = v.v1;
      bus.req1_alu_op = v.op1;
      bus.req1_op1    = v.a1;
      bus.req1_op2    = v.b1;
      bus.req1_branch = v.br1;
      wa  = v.gnt ? v.a1 : v.a0;
      wop = v.gnt ? v.op1 : v.op0;
      #1;
      chk("req0_ready", bus.req0_ready, !v.gnt);
      chk("req1_ready", bus.req1_ready, v.gnt);
      tick();
      if (v.gnt) bus.req1_valid = 1'b0;
      else       bus.req0_valid = 1'b0;
      chk("exec_busy", bus.busy, 1);
      chk("exec_rsp0", bus.rsp0_valid, 0);
      chk("exec_rsp1", bus.rsp1_valid, 0);
      chk("exec_op1", bus.alu_op1, wa);
      chk("exec_aluop", bus.alu_alu_op, wop);
      tick();
      chk("rsp0_valid", bus.rsp0_valid, !v.gnt);
      chk("rsp1_valid", bus.rsp1_valid, v.gnt);
      chk("rsp_result", bus.rsp_result, v.res);
      if (v.chkz) chk("rsp_zero", bus.rsp_zero, v.z);
      if (v.gnt) bus.rsp1_ready = 1'b1;
      else       bus.rsp0_ready = 1'b1;
      tick();
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      chk("idle_busy", bus.busy, 0);
      chk("idle_rsp0", bus.rsp0_valid, 0);
      chk("idle_rsp1", bus.rsp1_valid, 0);
   endtask

   vec_t bp;

   initial begin
      tbl[0] = '{1, OP_SUB, 10, 3, BNONE,
                 1, OP_XOR, 32'hF0, 32'h0F, BNONE,
                 0, 7, 0, 0};
      tbl[1] = '{1, OP_ADD, 1, 1, BNONE,
                 1, OP_XOR, 32'hF0, 32'h0F, BNONE,
                 1, 32'hFF, 0, 0};
      tbl[2] = '{1, OP_ADD, 1, 1, BNONE,
                 1, OP_SUB, 9, 2, BNONE,
                 0, 2, 0, 0};
      tbl[3] = '{0, OP_ADD, 0, 0, BNONE,
                 1, OP_SUB, 9, 2, BNONE,
                 1, 7, 0, 0};
      tbl[4] = '{1, OP_ADD, 5, 7, BNONE,
                 0, OP_ADD, 0, 0, BNONE,
                 0, 12, 0, 0};
      tbl[5] = '{0, OP_ADD, 0, 0, BNONE,
                 1, OP_SUB, 4, 4, BEQ,
                 1, 0, 1, 1};
      tbl[6] = '{0, OP_ADD, 0, 0, BNONE,
                 1, OP_SUB, 4, 3, BEQ,
                 1, 1, 1, 0};
      tbl[7] = '{0, OP_ADD, 0, 0, BNONE,
                 1, OP_SUB, 4, 3, BNE,
                 1, 1, 1, 1};

      rst_n           = 1'b0;
      bus.req0_valid  = 1'b1;
      bus.req0_alu_op = OP_ADD;
      bus.req0_op1    = 32'd1;
      bus.req0_op2    = 32'd2;
      bus.req0_branch = BNONE;
      bus.req1_valid  = 1'b1;
      bus.req1_alu_op = OP_ADD;
      bus.req1_op1    = 32'd3;
      bus.req1_op2    = 32'd4;
      bus.req1_branch = BNONE;
      bus.rsp0_ready  = 1'b0;
      bus.rsp1_ready  = 1'b0;
      tick();
      tick();
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp0", bus.rsp0_valid, 0);
      chk("rst_rsp1", bus.rsp1_valid, 0);
      chk("rst_result", bus.rsp_result, 0);
      chk("rst_zero", bus.rsp_zero, 0);
      chk("rst_alu_op1", bus.alu_op1, 0);
      chk("rst_alu_op2", bus.alu_op2, 0);
      chk("rst_alu_op", bus.alu_alu_op, 0);
      chk("rst_alu_br", bus.alu_branch, 0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++)
         run_op(tbl[i]);

      // backpressure on client 0 with client 1 waiting
      bus.req0_valid  = 1'b1;
      bus.req0_alu_op = OP_AND;
      bus.req0_op1    = 32'hFF;
      bus.req0_op2    = 32'h0F;
      bus.req0_branch = BNONE;
      #1;
      chk("bp_ready0", bus.req0_ready, 1);
      tick();
      bus.req0_valid = 1'b0;
      tick();
      bus.req1_valid  = 1'b1;
      bus.req1_alu_op = OP_OR;
      bus.req1_op1    = 32'h30;
      bus.req1_op2    = 32'h03;
      bus.req1_branch = BNONE;
      bus.req0_alu_op = OP_XOR;
      bus.req0_op1    = 32'h1234;
      bus.req0_op2    = 32'h5678;
      bus.req0_branch = BNE;
      for (int c = 0; c < 5; c++) begin
         bus.rsp1_ready = c[0];
         #1;
         chk("bp_rsp0", bus.rsp0_valid, 1);
         chk("bp_rsp1", bus.rsp1_valid, 0);
         chk("bp_result", bus.rsp_result, 32'h0F);
         chk("bp_busy", bus.busy, 1);
         chk("bp_ready1", bus.req1_ready, 0);
         chk("bp_alu_op1", bus.alu_op1, 32'hFF);
         chk("bp_alu_op2", bus.alu_op2, 32'h0F);
         chk("bp_alu_op", bus.alu_alu_op, OP_AND);
         chk("bp_alu_br", bus.alu_branch, BNONE);
         tick();
      end
      bus.rsp1_ready = 1'b0;
      bus.rsp0_ready = 1'b1;
      tick();
      bus.rsp0_ready = 1'b0;
      chk("bp_idle_busy", bus.busy, 0);
      chk("bp_ready1_go", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      tick();
      chk("bp_rsp1_valid", bus.rsp1_valid, 1);
      chk("bp_rsp1_result", bus.rsp_result, 32'h33);
      bus.rsp1_ready = 1'b1;
      tick();
      bus.rsp1_ready = 1'b0;
      chk("bp_end_busy", bus.busy, 0);

      // reset during EXEC
      bus.req0_valid  = 1'b1;
      bus.req0_alu_op = OP_ADD;
      bus.req0_op1    = 32'd2;
      bus.req0_op2    = 32'd3;
      bus.req0_branch = BNONE;
      tick();
      bus.req0_valid = 1'b0;
      chk("mr_exec_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy", bus.busy, 0);
      chk("mr_result", bus.rsp_result, 0);
      chk("mr_zero", bus.rsp_zero, 0);
      chk("mr_alu_op1", bus.alu_op1, 0);
      chk("mr_alu_op2", bus.alu_op2, 0);
      chk("mr_alu_op", bus.alu_alu_op, 0);
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mr_no_rsp0", bus.rsp0_valid, 0);
         chk("mr_no_rsp1", bus.rsp1_valid, 0);
      end
      bp = '{1, OP_ADD, 100, 23, BNONE,
             0, OP_ADD, 0, 0, BNONE,
             0, 123, 0, 0};
      run_op(bp);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared integer ALU. It accepts operation requests from two clients (port 0: execute stage, port 1: auxiliary address/compare unit). Each accepted operation's operands, alu_op and branch code are latched and presented to the combinational ALU for one full cycle. The registered result and branch flag are returned to the granted client with a valid/ready handshake. Grant is round-robin, so neither client can starve the other.

## Interface
- alu_op_size, 4, width of ALU operation code
- alu_operand_size, 32, width of operands and result
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  client has a pending operation
- req0_ready / req1_ready  out  1  arbiter accepts this cycle
- req0_alu_op / req1_alu_op  in  alu_op_size  operation code
- req0_op1, req0_op2 / req1_op1, req1_op2  in  alu_operand_size  operands
- req0_branch / req1_branch  in  3  branch type forwarded to ALU
- rsp0_valid / rsp1_valid  out  1  result available for that client
- rsp0_ready / rsp1_ready  in  1  client consumes result
- rsp_result  out  alu_operand_size  registered ALU result (shared bus)
- rsp_zero  out  1  registered ALU zero/branch-taken flag (shared)
- alu_alu_op  out  alu_op_size  to ALU alu_op
- alu_op1, alu_op2  out  alu_operand_size  to ALU operands
- alu_branch  out  3  to ALU branch
- alu_result  in  alu_operand_size  from ALU result
- alu_zero  in  1  from ALU zero
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready goes high only to the client selected by arbitration, and only when that client's valid is high. The other ready stays low.
  - Selection: if only one valid is high, that client wins.
  - If both valid are high, the client named by priority pointer prio wins. prio resets to 0.
  - On handshake (valid && ready): latch alu_op, op1, op2, branch and the grant id, then go to EXEC.
- EXEC: the latched fields drive the alu_* outputs. At the end of the cycle, alu_result goes into rsp_result and alu_zero goes into rsp_zero. Then go to RESP.
- RESP: rsp_valid is high for the granted client only. rsp_result and rsp_zero are held stable.
  - On rsp_ready for that client: go to IDLE and set prio to the non-granted client.
  - rsp_ready from the non-granted client is ignored.
- The alu_* outputs always reflect the latched fields, including in IDLE and RESP. Latched fields change only on a request handshake.
- rsp_zero is meaningful only when the latched branch is a defined branch code. For other codes the bench treats it as don't-care.
- Requests are not queued. A client holds valid and its fields stable until it sees ready.

## Timing
- Reset (asynchronous, rst_n low):
  - FSM goes to IDLE, prio=0, grant id=0.
  - All ready and rsp_valid outputs are 0; busy=0.
  - rsp_result=0, rsp_zero=0.
  - Latched fields are 0, so all alu_* outputs are 0.
- Reset asserted mid-operation aborts the operation. No rsp_valid is issued afterwards.
- Request handshake in cycle N gives EXEC in N+1 and rsp_valid high in N+2. Minimum latency is 2 cycles.
- If rsp_ready is high in the first RESP cycle, IDLE is entered at N+3 and the next handshake can occur in N+3. Peak throughput is one operation per 3 cycles.
- rsp_valid stays high indefinitely until rsp_ready; there is no timeout.
- req_ready is combinational from req_valid, state and prio. It never depends on rsp_ready.
- prio updates only on response completion. Simultaneous requests therefore alternate 0,1,0,1.

## Test plan
- Single op: req0 ADD, op1=5, op2=7.
  - Expect req0_ready in the same cycle.
  - Expect rsp0_valid 2 cycles later with rsp_result=12.
  - rsp1_valid stays 0 throughout.
- Contention: both valid from reset; req0 SUB 10-3, req1 XOR 0xF0^0x0F.
  - Expect first grant to client 0 with result 7.
  - Expect second grant to client 1 with result 0xFF.
  - A third simultaneous pair is granted to 0 again.
- Branch flag: req1 SUB 4-4 with branch=BEQ gives rsp_zero=1, rsp_result=0. Repeat with 4-3 and expect rsp_zero=0.
- Backpressure: hold rsp0_ready=0 for 5 cycles after rsp0_valid.
  - rsp_result stays stable and busy=1.
  - req1_ready stays 0.
  - rsp1_ready pulses are ignored.
  - Release rsp0_ready and expect IDLE on the next cycle.
- Reset mid-EXEC: pull rst_n low during EXEC.
  - All outputs go to reset values immediately.
  - After release, no rsp_valid appears and a new request completes normally.
- Stability: change req0 fields while rsp0_valid is pending and verify the alu_* outputs stay unchanged.
